rename_freelist: RTL and testbench

//  Physical-register free list feeding the rename stage. Hands out up to 4 free

---
 rtl/rename_freelist.sv | 113 +++++++++++
 tb/tb_rename_freelist.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rename_freelist.sv
// Physical-register free list for rename: up to 4 tag grants and 4 commit
// releases per cycle, with a retire-side head so a flush recovers squashed tags.
module rename_freelist #(
  parameter int PRF_WIDTH = 6,
  parameter int FL_DEPTH  = 32,
  parameter int FL_AW     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           alloc_req,
  output logic                 alloc_ok,
  output logic [PRF_WIDTH-1:0] alloc_prd0,
  output logic [PRF_WIDTH-1:0] alloc_prd1,
  output logic [PRF_WIDTH-1:0] alloc_prd2,
  output logic [PRF_WIDTH-1:0] alloc_prd3,
  input  logic [3:0]           rel_v,
  input  logic [PRF_WIDTH-1:0] rel_prd0,
  input  logic [PRF_WIDTH-1:0] rel_prd1,
  input  logic [PRF_WIDTH-1:0] rel_prd2,
  input  logic [PRF_WIDTH-1:0] rel_prd3,
  input  logic [2:0]           cmt_num,
  input  logic                 flush,
  output logic [FL_AW:0]       free_cnt,
  output logic                 rel_ovf
);

  localparam int CW = FL_AW + 2;

  logic [PRF_WIDTH-1:0] fifo [FL_DEPTH];
  logic [FL_AW-1:0]     head, tail, rhead;
  logic [FL_AW:0]       count, rcount;

  logic [2:0]           nreq, nrel, nalloc, nacc;
  logic [2:0]           rank [4];
  logic [PRF_WIDTH-1:0] prd [4];
  logic [PRF_WIDTH-1:0] rel_in [4];
  logic [PRF_WIDTH-1:0] rel_pk [4];
  logic [CW-1:0]        space, count_n, rcount_n;
  logic [FL_AW-1:0]     head_n, rhead_n, tail_n;
  logic                 ovf_now;

  assign rel_in[0] = rel_prd0;
  assign rel_in[1] = rel_prd1;
  assign rel_in[2] = rel_prd2;
  assign rel_in[3] = rel_prd3;

  always_comb begin
    nreq   = '0;
    nrel   = '0;
    rel_pk = '{default: '0};
    for (int unsigned k = 0; k < 4; k++) begin
      rank[k] = nreq;
      if (alloc_req[k]) nreq = nreq + 3'd1;
      if (rel_v[k]) begin
        rel_pk[nrel[1:0]] = rel_in[k];
        nrel = nrel + 3'd1;
      end
    end
    alloc_ok = ((FL_AW+1)'(nreq) <= count) & ~flush;
    for (int unsigned k = 0; k < 4; k++)
      prd[k] = alloc_req[k] ? fifo[head + FL_AW'(rank[k])] : '0;
    nalloc = alloc_ok ? nreq : 3'd0;

    // Room left for releases, measured against the count this cycle settles on
    // (rewound retire-side count on flush, post-allocation count otherwise).
    if (flush)
      space = CW'(FL_DEPTH) - CW'(rcount) + CW'(cmt_num);
    else
      space = CW'(FL_DEPTH) - CW'(count) + CW'(nalloc);
    ovf_now = CW'(nrel) > space;
    nacc    = ovf_now ? space[2:0] : nrel;

    rcount_n = CW'(rcount) + CW'(nacc) - CW'(cmt_num);
    rhead_n  = rhead + FL_AW'(cmt_num);
    tail_n   = tail + FL_AW'(nacc);
    if (flush) begin
      count_n = rcount_n;
      head_n  = rhead_n;
    end else begin
      count_n = CW'(count) - CW'(nalloc) + CW'(nacc);
      head_n  = head + FL_AW'(nalloc);
    end
  end

  assign alloc_prd0 = prd[0];
  assign alloc_prd1 = prd[1];
  assign alloc_prd2 = prd[2];
  assign alloc_prd3 = prd[3];
  assign free_cnt   = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++)
        fifo[i] <= PRF_WIDTH'(FL_DEPTH + i);
      head    <= '0;
      tail    <= '0;
      rhead   <= '0;
      count   <= (FL_AW+1)'(FL_DEPTH);
      rcount  <= (FL_AW+1)'(FL_DEPTH);
      rel_ovf <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < 4; k++)
        if (3'(k) < nacc) fifo[tail + FL_AW'(k)] <= rel_pk[k];
      head   <= head_n;
      tail   <= tail_n;
      rhead  <= rhead_n;
      count  <= count_n[FL_AW:0];
      rcount <= rcount_n[FL_AW:0];
      if (ovf_now) rel_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rename_freelist.sv
// Directed bench for rename_freelist: the driver queues expected outputs per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_rename_freelist;

  localparam int K_OK = 0, K_P0 = 1, K_P1 = 2, K_P2 = 3, K_P3 = 4, K_CNT = 5, K_OVF = 6;

  typedef struct {
    string name;
    int    kind;
    int    val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] alloc_req = '0;
  logic       alloc_ok;
  logic [5:0] alloc_prd0, alloc_prd1, alloc_prd2, alloc_prd3;
  logic [3:0] rel_v = '0;
  logic [5:0] rel_prd0 = '0, rel_prd1 = '0, rel_prd2 = '0, rel_prd3 = '0;
  logic [2:0] cmt_num = '0;
  logic       flush = 1'b0;
  logic [5:0] free_cnt;
  logic       rel_ovf;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  rename_freelist #(.PRF_WIDTH(6), .FL_DEPTH(32), .FL_AW(5)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .alloc_prd0(alloc_prd0), .alloc_prd1(alloc_prd1),
    .alloc_prd2(alloc_prd2), .alloc_prd3(alloc_prd3),
    .rel_v(rel_v), .rel_prd0(rel_prd0), .rel_prd1(rel_prd1),
    .rel_prd2(rel_prd2), .rel_prd3(rel_prd3),
    .cmt_num(cmt_num), .flush(flush),
    .free_cnt(free_cnt), .rel_ovf(rel_ovf)
  );

  always #5 clk = ~clk;

  // Monitor: everything queued during a cycle is checked on its falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      int   act;
      e = q.pop_front();
      case (e.kind)
        K_OK:    act = int'(alloc_ok);
        K_P0:    act = int'(alloc_prd0);
        K_P1:    act = int'(alloc_prd1);
        K_P2:    act = int'(alloc_prd2);
        K_P3:    act = int'(alloc_prd3);
        K_CNT:   act = int'(free_cnt);
        default: act = int'(rel_ovf);
      endcase
      n_chk++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.val, $time);
      end
    end
  end

  task automatic expect_v(input string name, input int kind, input int val);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] rv,
                       input logic [5:0] r0, input logic [5:0] r1,
                       input logic [2:0] cmt, input logic fl);
    alloc_req = req; rel_v = rv; rel_prd0 = r0; rel_prd1 = r1;
    rel_prd2 = '0; rel_prd3 = '0; cmt_num = cmt; flush = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    // A: full-width grant after reset
    do_reset();
    expect_v("A_rst_cnt", K_CNT, 32);
    expect_v("A_rst_ovf", K_OVF, 0);
    next_cycle();
    drive(4'b1111, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("A_ok", K_OK, 1);
    expect_v("A_p0", K_P0, 32);
    expect_v("A_p1", K_P1, 33);
    expect_v("A_p2", K_P2, 34);
    expect_v("A_p3", K_P3, 35);
    next_cycle();
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("A_cnt", K_CNT, 28);
    next_cycle();

    // B: sparse request packs in slot order, idle slots read 0
    do_reset();
    drive(4'b1010, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("B_ok", K_OK, 1);
    expect_v("B_p0", K_P0, 0);
    expect_v("B_p1", K_P1, 32);
    expect_v("B_p2", K_P2, 0);
    expect_v("B_p3", K_P3, 33);
    next_cycle();
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("B_cnt", K_CNT, 30);
    next_cycle();

    // C: drain the list, then a single request is refused and head holds
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
      expect_v("C_ok", K_OK, 1);
      expect_v("C_p0", K_P0, 32 + 4 * i);
      expect_v("C_cnt", K_CNT, 32 - 4 * i);
      next_cycle();
    end
    drive(4'b0001, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("C_empty_ok", K_OK, 0);
    expect_v("C_empty_cnt", K_CNT, 0);
    next_cycle();
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("C_hold_cnt", K_CNT, 0);
    next_cycle();

    // D: same-cycle release is invisible; next cycle grants wrapped entries
    drive(4'b0011, 4'b0011, 6'd40, 6'd41, 3'd0, 1'b0);
    expect_v("D_refuse_ok", K_OK, 0);
    next_cycle();
    drive(4'b0011, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("D_cnt", K_CNT, 2);
    expect_v("D_ok", K_OK, 1);
    expect_v("D_p0", K_P0, 40);
    expect_v("D_p1", K_P1, 41);
    next_cycle();
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("D_after_cnt", K_CNT, 0);
    next_cycle();

    // E: reset mid-operation, then commit 2 of 4 and flush
    do_reset();
    expect_v("E_rst_cnt", K_CNT, 32);
    next_cycle();
    drive(4'b1111, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    next_cycle();
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 3'd2, 1'b0);
    expect_v("E_cmt_cnt", K_CNT, 28);
    next_cycle();
    drive(4'b0001, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b1);
    expect_v("E_flush_ok", K_OK, 0);
    next_cycle();
    drive(4'b0001, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("E_cnt", K_CNT, 30);
    expect_v("E_ok", K_OK, 1);
    expect_v("E_p0", K_P0, 34);
    next_cycle();
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("E_after_cnt", K_CNT, 29);
    next_cycle();

    // F: release into a full list is dropped and latches the sticky error
    do_reset();
    drive(4'b0000, 4'b0001, 6'd10, 6'd0, 3'd0, 1'b0);
    expect_v("F_pre_ovf", K_OVF, 0);
    next_cycle();
    drive(4'b0000, 4'b0000, 6'd0, 6'd0, 3'd0, 1'b0);
    expect_v("F_ovf", K_OVF, 1);
    expect_v("F_cnt", K_CNT, 32);
    next_cycle();
    expect_v("F_sticky", K_OVF, 1);
    expect_v("F_p_none", K_P0, 0);
    next_cycle();

    for (int i = 0; i < 10 && q.size() > 0; i++) next_cycle();
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d checks left unconsumed, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
